// File: rtl/fft_stage_sequencer_pkg.sv
// Shared definitions for the FFT stage sequencer.
//   state_e       : sequencer FSM states
//   err_code_t    : error code reported on err_code
//   ERR_*         : error code values
//   GAP_CNT_W     : width of the inter-stage gap counter
//   GAP_MAX       : largest supported inter-stage gap
//   timer_width() : width of the saturating timeout counter for a given TIMEOUT
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StGap,
        StDone
    } state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE     = 2'b00;
    localparam err_code_t ERR_TIMEOUT  = 2'b01;
    localparam err_code_t ERR_SPURIOUS = 2'b10;
    localparam err_code_t ERR_ABORT    = 2'b11;

    localparam int unsigned GAP_CNT_W = 4;
    localparam int unsigned GAP_MAX   = 15;

    // One spare bit above clog2 so the counter can saturate past TIMEOUT-1.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Handshake bundle between the FFT stage sequencer and its environment
// (input loader on the frame side, butterfly stages on the stage side).
//   frame_req   : frame request from the loader, held until frame_ack
//   frame_ack   : one-cycle acceptance pulse
//   abort       : synchronous abort of the running frame
//   stage_start : one-hot, one-cycle start pulse per stage
//   stage_done  : per-stage completion pulses
//   cur_stage   : index of the stage being started or awaited
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last stage completes
//   error       : sticky error flag
//   err_code    : cause of the last error
// Modports: master = sequencer side, slave = loader/stage side.
interface fft_stage_sequencer_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned SW     = 2
);
    import fft_ctrl_pkg::*;

    logic              frame_req;
    logic              frame_ack;
    logic              abort;
    logic [STAGES-1:0] stage_start;
    logic [STAGES-1:0] stage_done;
    logic [SW-1:0]     cur_stage;
    logic              busy;
    logic              frame_done;
    logic              error;
    err_code_t         err_code;

    modport master (
        input  frame_req,
        input  abort,
        input  stage_done,
        output frame_ack,
        output stage_start,
        output cur_stage,
        output busy,
        output frame_done,
        output error,
        output err_code
    );

    modport slave (
        output frame_req,
        output abort,
        output stage_done,
        input  frame_ack,
        input  stage_start,
        input  cur_stage,
        input  busy,
        input  frame_done,
        input  error,
        input  err_code
    );

endinterface

// File: rtl/fft_stage_sequencer_cycle_timer.sv
// fft_cycle_timer: loadable, saturating up-counter with a terminal-count flag.
// Used for both the per-stage timeout and the inter-stage gap.
//   clk   : system clock
//   rst_n : asynchronous reset, active high
//   load  : clear the count to zero (wins over en)
//   en    : increment the count
//   limit : terminal count value
//   tc    : count equals limit
module fft_cycle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: walks one frame through the STAGES butterfly stages.
// Accepts frame_req, issues a one-hot start pulse per stage, waits for that
// stage's done pulse, inserts GAP idle cycles between stages, and reports
// frame_done or a sticky error (timeout, unexpected done, abort).
//   clk   : system clock
//   rst_n : asynchronous reset, ACTIVE HIGH (legacy name kept)
//   bus   : handshake bundle, master side (see fft_stage_sequencer_if)
// All outputs are registered.
module fft_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned N       = 16,
    parameter int unsigned STAGES  = 4,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned SW      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_stage_sequencer_if.master bus
);

    if ((STAGES != $clog2(N)) || ((1 << STAGES) != N) || (N < 4) || (GAP > GAP_MAX) ||
        (SW != $clog2(STAGES)) || (TIMEOUT < 2)) begin : g_param_check
        $fatal(1, "fft_stage_sequencer: illegal parameter combination");
    end

    localparam int unsigned TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = (GAP == 0) ? '0 : GAP_CNT_W'(GAP - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

    state_e            state_q, state_d;
    logic [SW-1:0]     cur_stage_q, cur_stage_d;
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    err_code_t         err_code_q, err_code_d;
    logic              frame_ack_q, frame_ack_d;
    logic              frame_done_q, frame_done_d;
    logic [STAGES-1:0] stage_start_q, stage_start_d;

    logic              fail;
    err_code_t         fail_code;
    logic [STAGES-1:0] stage_mask;
    logic              done_expected;
    logic              done_spurious;
    logic              to_load, to_en, to_tc;
    logic              gap_load, gap_en, gap_tc;

    assign stage_mask    = STAGES'(1) << cur_stage_q;
    assign done_expected = |(bus.stage_done & stage_mask);
    assign done_spurious = |(bus.stage_done & ~stage_mask);

    // Timeout window opens on the start cycle itself so the error lands
    // exactly TIMEOUT cycles after stage_start.
    assign to_load  = (state_d == StStart);
    assign to_en    = (state_q == StStart) || (state_q == StWait);
    assign gap_load = (state_d == StGap) && (state_q != StGap);
    assign gap_en   = (state_q == StGap);

    fft_cycle_timer #(
        .W (TW)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (to_load),
        .en    (to_en),
        .limit (TO_LAST),
        .tc    (to_tc)
    );

    fft_cycle_timer #(
        .W (GAP_CNT_W)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (gap_load),
        .en    (gap_en),
        .limit (GAP_LAST),
        .tc    (gap_tc)
    );

    always_comb begin
        state_d       = state_q;
        cur_stage_d   = cur_stage_q;
        busy_d        = busy_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        frame_ack_d   = 1'b0;
        frame_done_d  = 1'b0;
        stage_start_d = '0;
        fail          = 1'b0;
        fail_code     = ERR_NONE;

        unique case (state_q)
            StIdle: begin
                if (bus.frame_req) begin
                    state_d     = StStart;
                    frame_ack_d = 1'b1;
                    busy_d      = 1'b1;
                    cur_stage_d = '0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (done_expected) begin
                    if (cur_stage_q == LAST_STAGE) begin
                        state_d = StDone;
                    end else if (GAP == 0) begin
                        state_d     = StStart;
                        cur_stage_d = cur_stage_q + SW'(1);
                    end else begin
                        state_d = StGap;
                    end
                end else if (to_tc) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end
            end
            StGap: begin
                if (gap_tc) begin
                    state_d     = StStart;
                    cur_stage_d = cur_stage_q + SW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort beats everything; an unexpected done beats the expected one.
        if (state_q != StIdle) begin
            if (bus.abort) begin
                fail      = 1'b1;
                fail_code = ERR_ABORT;
            end else if (done_spurious) begin
                fail      = 1'b1;
                fail_code = ERR_SPURIOUS;
            end
        end

        if (fail) begin
            state_d     = StIdle;
            cur_stage_d = cur_stage_q;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_code_d  = fail_code;
        end

        // Pulses are derived from the next state so they line up with it.
        if (state_d == StStart) begin
            stage_start_d = STAGES'(1) << cur_stage_d;
        end
        if (state_d == StDone) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= StIdle;
            cur_stage_q   <= '0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_ack_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            stage_start_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_stage_q   <= cur_stage_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            frame_ack_q   <= frame_ack_d;
            frame_done_q  <= frame_done_d;
            stage_start_q <= stage_start_d;
        end
    end

    assign bus.frame_ack   = frame_ack_q;
    assign bus.stage_start = stage_start_q;
    assign bus.cur_stage   = cur_stage_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.error       = error_q;
    assign bus.err_code    = err_code_q;

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Controller that sequences one FFT frame through the STAGES butterfly stages of the pipelined decimation-in-time FFT. It accepts a frame-start request, issues a one-cycle start pulse to each stage in order, and waits for that stage's completion pulse. It enforces an inter-stage guard gap and a per-stage timeout, then reports frame completion or an error. It sits between the input loader and the chain of inter-stage butterfly blocks.

Parameters:
N, 16, FFT length in points (power of two, >= 4)
STAGES, 4, number of butterfly stages; must equal log2(N)
GAP, 2, idle cycles between stage_done[k] and stage_start[k+1] (0..15)
TIMEOUT, 1024, maximum cycles from stage_start[k] to stage_done[k] before error
SW, 2, width of the stage index; equals clog2(STAGES)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-high reset; the codebase port name is kept, and the logic asserts reset while rst_n=1
frame_req  in  1  request to process a frame; input RAM is loaded
frame_ack  out  1  one-cycle pulse; frame_req accepted
abort  in  1  synchronous abort of the current frame
stage_start  out  STAGES  one-hot, one-cycle start pulse per stage
stage_done  in  STAGES  per-stage completion pulse (start_next_stage of each stage)
cur_stage  out  SW  index of the stage currently started or awaited
busy  out  1  high from acceptance until frame_done or error
frame_done  out  1  one-cycle pulse after the last stage completes
error  out  1  sticky error flag; cleared only by the next accepted frame_req or by reset
err_code  out  2  00 none, 01 timeout, 10 unexpected done, 11 abort

Behaviour:
- Reset, asynchronous: state=IDLE; all counters=0; every output=0.
- States: IDLE, START, WAIT, GAP, DONE. All outputs are registered.
- IDLE:
  - A sampled frame_req=1 pulses frame_ack the next cycle, sets busy=1, cur_stage=0, clears error/err_code, and moves to START.
  - frame_req while busy is ignored. The requester holds frame_req until frame_ack.
- START:
  - Drives stage_start = 1<<cur_stage for exactly one cycle.
  - Loads the timeout counter to 0, then moves to WAIT.
- WAIT:
  - The counter increments each cycle.
  - stage_done[cur_stage]=1: if cur_stage==STAGES-1, go to DONE; else go to GAP with the gap counter=0. If GAP=0, go straight to START with cur_stage+1.
  - Counter reaches TIMEOUT-1 without done: error=1, err_code=01, busy=0, go to IDLE. No frame_done.
  - A done bit on any other stage index in any non-IDLE state: error=1, err_code=10, return to IDLE. This takes priority over the expected done in the same cycle.
- GAP: counts GAP cycles, then increments cur_stage and moves to START. Latency from stage_done to the next stage_start is GAP+1 cycles.
- DONE: frame_done=1 for one cycle, busy=0, next state IDLE. A frame_req present in the DONE cycle is sampled in IDLE on the following cycle; there is no back-to-back acceptance in DONE.
- abort=1 in any non-IDLE state: next cycle error=1, err_code=11, busy=0, IDLE, no stage_start issued. abort has priority over all other events; abort in IDLE is ignored.
- stage_done bits while IDLE are ignored and do not set an error.
- A reset mid-frame returns everything to reset values immediately. No pulse is emitted on reset release.
- Widths:
  - Timeout counter: clog2(TIMEOUT)+1 bits, saturating.
  - Gap counter: 4 bits.
  - cur_stage never exceeds STAGES-1.
- Elaboration check: fatal if STAGES != log2(N) or GAP > 15.

Decomposition:
- Shared package fft_ctrl_pkg:
  - state enum (IDLE, START, WAIT, GAP, DONE)
  - err_code localparams ERR_NONE, ERR_TIMEOUT, ERR_SPURIOUS, ERR_ABORT
  - clog2-based width constants
- One natural sub-module: fft_cycle_timer, a loadable up-counter with terminal-count flag, reused for both the timeout and gap counters.

Test Plan:
- Nominal frame, N=16, GAP=2: each stage returns done 10 cycles after start. Required:
  - frame_ack 1 cycle after frame_req
  - stage_start 0001, 0010, 0100, 1000 each 3 cycles after the previous done
  - frame_done 1 cycle after stage_done[3]; busy falls with it
- Timeout, TIMEOUT=1024: stage 2 never returns done. Required: error=1, err_code=01 exactly 1024 cycles after stage_start[2]; busy=0; no frame_done; no stage_start[3].
- Spurious done: in WAIT on stage 1, pulse stage_done[3]. Required: error=1, err_code=10 on the next cycle; state IDLE. A subsequent frame_req clears error and runs a full frame.
- Abort in GAP after stage 0: Required: no stage_start[1]; err_code=11; busy=0 one cycle later.
- Reset mid-WAIT (stage 2): assert rst_n=1 asynchronously. Required: all outputs 0 immediately. After release, frame_req completes a clean frame.
- GAP=0 and back-to-back frames: done to next start in 1 cycle. frame_req held across DONE is acked 2 cycles after frame_done.
